// File: rtl/approx_mult_error_monitor.sv
// Receive-side error monitor for an approximate multiplier: computes the exact
// product of each accepted sample and accumulates saturating error statistics.
module approx_mult_error_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2*WIDTH-1:0]   product_i,
    input  logic                 clear_i,
    output logic [CNT_W-1:0]     sample_count_o,
    output logic [CNT_W-1:0]     mismatch_count_o,
    output logic [ACC_W-1:0]     err_sum_o,
    output logic [2*WIDTH-1:0]   err_max_o,
    output logic [WIDTH-1:0]     max_a_o,
    output logic [WIDTH-1:0]     max_b_o,
    output logic [2*WIDTH-1:0]   last_err_o,
    output logic                 last_err_valid_o,
    output logic                 saturated_o
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             accept;
    logic             clear_req;
    logic             flush;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [PW-1:0]    s1_prod;
    logic [PW-1:0]    s1_exact;
    logic [PW-1:0]    exact_in;

    logic [PW-1:0]    err;
    logic             update;
    logic             cnt_full;
    logic             mis_full;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_next;
    logic             sat_event;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept    = valid_i & ready_o;
    assign clear_req = (state == ST_RUN) & clear_i;
    // A clear request and the CLEAR state both suppress statistic updates.
    assign flush     = clear_req | (state == ST_CLEAR);
    assign exact_in  = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    // Next-state decode; clear_i only matters in RUN.
    always_comb begin
        state_next = ST_INIT;
        case (state)
            ST_INIT:  state_next = ST_RUN;
            ST_RUN:   state_next = clear_i ? ST_CLEAR : ST_RUN;
            ST_CLEAR: state_next = ST_RUN;
            default:  state_next = ST_INIT;
        endcase
    end

    // State register; ready_o tracks the registered state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            ready_o <= 1'b0;
        end else begin
            state   <= state_next;
            ready_o <= (state_next == ST_RUN);
        end
    end

    // Stage 1: capture the sample and its exact product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_prod  <= '0;
            s1_exact <= '0;
        end else begin
            s1_valid <= (state == ST_CLEAR) ? 1'b0 : accept;
            if (accept) begin
                s1_a     <= a_i;
                s1_b     <= b_i;
                s1_prod  <= product_i;
                s1_exact <= exact_in;
            end else begin
                s1_a     <= s1_a;
                s1_b     <= s1_b;
                s1_prod  <= s1_prod;
                s1_exact <= s1_exact;
            end
        end
    end

    // Stage 2 arithmetic: absolute error and saturating accumulation.
    always_comb begin
        err       = '0;
        update    = 1'b0;
        cnt_full  = 1'b0;
        mis_full  = 1'b0;
        sum_wide  = '0;
        sum_next  = '0;
        sat_event = 1'b0;
        if (s1_exact >= s1_prod) begin
            err = s1_exact - s1_prod;
        end else begin
            err = s1_prod - s1_exact;
        end
        update   = s1_valid & ~flush;
        cnt_full = &sample_count_o;
        mis_full = (&mismatch_count_o) & (err != '0);
        sum_wide = {1'b0, err_sum_o} + (ACC_W + 1)'(err);
        if (sum_wide[ACC_W]) begin
            sum_next = '1;
        end else begin
            sum_next = sum_wide[ACC_W-1:0];
        end
        sat_event = cnt_full | mis_full | sum_wide[ACC_W];
    end

    // Stage 2 registers: statistics, max tracking and the last-error pulse.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sample_count_o   <= '0;
            mismatch_count_o <= '0;
            err_sum_o        <= '0;
            err_max_o        <= '0;
            max_a_o          <= '0;
            max_b_o          <= '0;
            last_err_o       <= '0;
            last_err_valid_o <= 1'b0;
            saturated_o      <= 1'b0;
        end else if (update) begin
            sample_count_o   <= sat_inc(sample_count_o);
            mismatch_count_o <= (err != '0) ? sat_inc(mismatch_count_o) : mismatch_count_o;
            err_sum_o        <= sum_next;
            last_err_o       <= err;
            last_err_valid_o <= 1'b1;
            saturated_o      <= saturated_o | sat_event;
            // Strict compare keeps the first of equal errors.
            if (err > err_max_o) begin
                err_max_o <= err;
                max_a_o   <= s1_a;
                max_b_o   <= s1_b;
            end else begin
                err_max_o <= err_max_o;
                max_a_o   <= max_a_o;
                max_b_o   <= max_b_o;
            end
        end else begin
            last_err_valid_o <= 1'b0;
        end
    end

endmodule
